fifo_event_reader: RTL and testbench
====================================

Name: fifo_event_reader

Overview:
Drains captured ADC samples from the readout FIFO, which is filled one word per read clock during a triggered readout of NUM_DATA samples. Frames each event as one AXI-Stream packet: a header word, then exactly NUM_DATA data words, with tlast on the final word. Pads short events after a starvation timeout so the downstream DMA never hangs. Keeps event and timeout counters for the register interface.

Parameters:
NUM_DATA, 1280, data words per event (>=1)
DATA_WIDTH, 32, FIFO and stream word width (fixed 32)
EVT_COUNTER_LENGTH, 16, width of event_count and timeout_count (<=16)
TIMEOUT_CYCLES, 4096, consecutive empty cycles mid-event before padding (>=1)
HEADER_MAGIC, 16'hEB90, upper half of header word

Ports:
clk  in  1  IP clock, same domain as the FIFO read side
rst  in  1  asynchronous active-high reset
enable  in  1  permits starting a new event; sampled in IDLE only
fifo_dout  in  DATA_WIDTH  first-word-fall-through FIFO head, valid when !fifo_empty
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  pop strobe, one word per asserted cycle
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  last word of event
m_axis_tuser  out  1  word is timeout padding
event_count  out  EVT_COUNTER_LENGTH  completed events, wraps
timeout_count  out  EVT_COUNTER_LENGTH  events that needed padding, wraps
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, word_idx=0, idle_cnt=0, event_count=0, timeout_count=0. All outputs 0. FIFO contents are not touched; the FIFO shares rst.
- Handshake: a word transfers when tvalid && tready. Once tvalid is high, tdata, tlast and tuser are held until the transfer completes.
- IDLE: tvalid=0, fifo_rd_en=0. If enable && !fifo_empty, go to HEADER on the next cycle.
- HEADER:
  - tvalid=1, tdata={HEADER_MAGIC, zero-extended event_count}, tlast=0, tuser=0, fifo_rd_en=0.
  - On transfer: go to DATA, word_idx=0, idle_cnt=0.
- DATA:
  - tvalid=!fifo_empty, tdata=fifo_dout, tuser=0, tlast=(word_idx==NUM_DATA-1).
  - fifo_rd_en=tvalid && tready (combinational, zero latency). The FIFO is never popped when empty.
  - On transfer: word_idx++ and idle_cnt=0. If tlast, event_count++ and go to IDLE.
  - While fifo_empty: idle_cnt++. When idle_cnt reaches TIMEOUT_CYCLES-1 while still empty, go to PAD next cycle and timeout_count++.
  - Backpressure with data present (fifo non-empty, tready=0) does not advance idle_cnt.
- PAD:
  - tvalid=1, tdata=0, tuser=1, tlast=(word_idx==NUM_DATA-1), fifo_rd_en=0.
  - On transfer: word_idx++. If tlast, event_count++ and go to IDLE.
  - Late FIFO data is left for the next event.
- Widths: word_idx and idle_cnt are sized with $clog2(max+1). Counters wrap modulo 2^EVT_COUNTER_LENGTH.
- enable deasserted mid-event: the current event completes normally; no new event starts.
- Back-to-back events: the cycle after the tlast transfer is always IDLE. A new HEADER is presented no earlier than 2 cycles after the tlast transfer.
- NUM_DATA=1: the first DATA word carries tlast.
- Reset mid-event: the packet is truncated with no tlast, and outputs drop immediately. Downstream must also be reset by rst.

Test Plan:
1. NUM_DATA=4; FIFO preloaded 1,2,3,4; enable=1; tready=1 -> stream EB900000,1,2,3,4 with tlast on 4; event_count=1; 4 fifo_rd_en pulses.
2. Random tready (~50%) over 3 events of 1280 words -> no lost or duplicated words; headers carry counts 0,1,2; tdata stable while tvalid && !tready.
3. TIMEOUT_CYCLES=8, NUM_DATA=4; only words A,B present -> header,A,B, then 8 empty cycles, then 0,0 with tuser=1 and tlast on the second pad; timeout_count=1.
4. enable=0 with FIFO non-empty -> tvalid stays 0, fifo_rd_en stays 0; enable drop during DATA -> event completes, then IDLE.
5. rst pulse after 2 data words -> all outputs 0 asynchronously; counters 0; after release with FIFO refilled, the next header shows count 0.
6. event_count preset by running 65536 events with NUM_DATA=1 -> wraps to 0 and header count reads 0000.

Source files
------------

// File: rtl/fifo_event_reader_if.sv
// FIFO read-side and AXI-Stream master signals of the event reader.
// The reader takes the master view and the FIFO/stream environment takes the slave view.
interface fifo_event_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic                  m_axis_tuser;

    modport master (
        input  fifo_dout, fifo_empty, m_axis_tready,
        output fifo_rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    modport slave (
        output fifo_dout, fifo_empty, m_axis_tready,
        input  fifo_rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/fifo_event_reader.sv
// Drains a first-word-fall-through FIFO into AXI-Stream packets: one header word plus
// NUM_DATA data words per event, padding with tuser-marked zeros when the FIFO starves.
module fifo_event_reader #(
    parameter int          NUM_DATA           = 1280,
    parameter int          DATA_WIDTH         = 32,
    parameter int          EVT_COUNTER_LENGTH = 16,
    parameter int          TIMEOUT_CYCLES     = 4096,
    parameter logic [15:0] HEADER_MAGIC       = 16'hEB90
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    fifo_event_reader_if.master           bus,
    output logic [EVT_COUNTER_LENGTH-1:0] event_count,
    output logic [EVT_COUNTER_LENGTH-1:0] timeout_count,
    output logic                          busy
);
    localparam int IDX_W  = $clog2(NUM_DATA + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_DATA - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [EVT_COUNTER_LENGTH-1:0] CNT_ONE = EVT_COUNTER_LENGTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
        S_PAD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  word_idx;
    logic [IDLE_W-1:0] idle_cnt;
    logic              xfer;
    logic              last_word;
    logic              timed_out;

    assign xfer      = bus.m_axis_tvalid && bus.m_axis_tready;
    assign last_word = (word_idx == LAST_IDX);
    assign timed_out = bus.fifo_empty && (idle_cnt == IDLE_LIMIT);

    // NOTE: every output is decoded from registered state, so an asynchronous reset
    // forces the stream and pop strobe to zero without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (enable && !bus.fifo_empty) state_next = S_HEADER;
            S_HEADER: if (xfer) state_next = S_DATA;
            S_DATA: begin
                if (xfer && last_word) state_next = S_IDLE;
                else if (timed_out)    state_next = S_PAD;
            end
            S_PAD:    if (xfer && last_word) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
    always_comb begin
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tdata  = '0;
        bus.m_axis_tlast  = 1'b0;
        bus.m_axis_tuser  = 1'b0;
        bus.fifo_rd_en    = 1'b0;
        busy              = (state != S_IDLE);
        case (state)
            S_HEADER: begin
                bus.m_axis_tvalid = 1'b1;
                bus.m_axis_tdata  = DATA_WIDTH'({HEADER_MAGIC, 16'(event_count)});
            end
            S_DATA: begin
                // The FIFO head is presented directly; popping on handshake keeps it held otherwise.
                bus.m_axis_tvalid = !bus.fifo_empty;
                bus.m_axis_tdata  = bus.fifo_dout;
                bus.m_axis_tlast  = last_word;
                bus.fifo_rd_en    = !bus.fifo_empty && bus.m_axis_tready;
            end
            S_PAD: begin
                bus.m_axis_tvalid = 1'b1;
                bus.m_axis_tuser  = 1'b1;
                bus.m_axis_tlast  = last_word;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_idx      <= '0;
            idle_cnt      <= '0;
            event_count   <= '0;
            timeout_count <= '0;
        end else begin
            case (state)
                S_HEADER: begin
                    if (xfer) begin
                        word_idx <= '0;
                        idle_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        word_idx <= word_idx + 1'b1;
                        idle_cnt <= '0;
                        if (last_word) event_count <= event_count + CNT_ONE;
                    end else if (bus.fifo_empty) begin
                        // Backpressure with data waiting is not starvation, so only empty cycles count.
                        idle_cnt <= idle_cnt + 1'b1;
                        if (idle_cnt == IDLE_LIMIT) timeout_count <= timeout_count + CNT_ONE;
                    end
                end
                S_PAD: begin
                    if (xfer) begin
                        word_idx <= word_idx + 1'b1;
                        if (last_word) event_count <= event_count + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_event_reader.sv
// Scoreboard bench for fifo_event_reader: a modelled FIFO, per-event expected packets
// built from header/data/pad rules, and an independent stream monitor.
module tb_fifo_event_reader;
    localparam int NUM  = 4;
    localparam int TO   = 8;
    localparam int EVTW = 4;
    localparam int SB   = 1024;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [EVTW-1:0] event_count;
    logic [EVTW-1:0] timeout_count;
    logic            busy;

    fifo_event_reader_if #(.DATA_WIDTH(32)) bus ();

    fifo_event_reader #(
        .NUM_DATA(NUM),
        .DATA_WIDTH(32),
        .EVT_COUNTER_LENGTH(EVTW),
        .TIMEOUT_CYCLES(TO),
        .HEADER_MAGIC(16'hEB90)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .bus(bus.master),
        .event_count(event_count),
        .timeout_count(timeout_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // FIFO model: main process owns wr_ptr/mem, the pop process owns rd_ptr.
    logic [31:0] mem [0:4095];
    logic [11:0] wr_ptr;
    logic [11:0] rd_ptr;
    assign bus.fifo_empty = (rd_ptr == wr_ptr);
    assign bus.fifo_dout  = mem[rd_ptr];

    // Scoreboard: main pushes at exp_wr, monitor pops at exp_rd.
    logic [31:0] exp_data [0:SB-1];
    logic        exp_last [0:SB-1];
    logic        exp_user [0:SB-1];
    logic        exp_pop  [0:SB-1];
    int          exp_wr;
    int          exp_rd;

    int checks = 0;
    int errors = 0;

    logic            rand_tready;
    logic [EVTW-1:0] ev_model;
    logic [EVTW-1:0] to_model;

    int          cyc = 0;
    int          last_xfer_cyc = 0;
    int          pop_count = 0;
    logic        pop_pending = 1'b0;
    logic        in_pad = 1'b0;
    logic        have_hold = 1'b0;
    logic [34:0] held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        bus.m_axis_tready = rand_tready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr = wr_ptr;
        end else begin
            #1;
            if (pop_pending) rd_ptr = rd_ptr + 1'b1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_rd      = exp_wr;
            have_hold   = 1'b0;
            in_pad      = 1'b0;
            pop_pending = 1'b0;
        end else begin
            pop_pending = bus.fifo_rd_en;
            if (bus.fifo_rd_en) begin
                pop_count++;
                check("pop_when_empty", bus.fifo_empty, 1'b0);
            end
            if (have_hold)
                check("held_word", {bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser}, held);
            have_hold = bus.m_axis_tvalid && !bus.m_axis_tready;
            held      = {1'b1, bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser};
            if (bus.m_axis_tvalid && bus.m_axis_tuser && !in_pad) begin
                in_pad = 1'b1;
                check("timeout_gap", cyc - last_xfer_cyc, TO + 1);
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                if (exp_rd == exp_wr) begin
                    check("sb_word_pending", exp_wr - exp_rd, 1);
                end else begin
                    check("tdata", bus.m_axis_tdata, exp_data[exp_rd % SB]);
                    check("tlast", bus.m_axis_tlast, exp_last[exp_rd % SB]);
                    check("tuser", bus.m_axis_tuser, exp_user[exp_rd % SB]);
                    check("rd_en_on_xfer", bus.fifo_rd_en, exp_pop[exp_rd % SB]);
                    exp_rd++;
                end
                if (!bus.m_axis_tuser) last_xfer_cyc = cyc;
                if (bus.m_axis_tlast) in_pad = 1'b0;
            end else begin
                check("rd_en_no_xfer", bus.fifo_rd_en, 1'b0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic l, input logic u, input logic p);
        exp_data[exp_wr % SB] = d;
        exp_last[exp_wr % SB] = l;
        exp_user[exp_wr % SB] = u;
        exp_pop[exp_wr % SB]  = p;
        exp_wr++;
    endtask

    task automatic fifo_push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 1'b1;
    endtask

    // One event: header with the completed-event count, `present` FIFO words, zero pads for the rest.
    task automatic run_event(input int present, input int gap_max);
        logic [31:0] w;
        push_exp({16'hEB90, 12'h000, ev_model}, 1'b0, 1'b0, 1'b0);
        ev_model = ev_model + 1'b1;
        if (present < NUM) to_model = to_model + 1'b1;
        for (int i = 0; i < NUM; i++) begin
            if (i < present) begin
                w = $urandom;
                if (gap_max > 0) repeat ($urandom_range(0, gap_max)) step();
                push_exp(w, i == NUM - 1, 1'b0, 1'b1);
                fifo_push(w);
            end else begin
                push_exp(32'h0, i == NUM - 1, 1'b1, 1'b0);
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            step();
            if (exp_rd == exp_wr && !busy && bus.fifo_empty) break;
        end
        check("drained", {exp_wr != exp_rd, busy, bus.fifo_empty}, 3'b001);
    endtask

    initial begin
        int base;
        rst         = 1'b1;
        enable      = 1'b0;
        rand_tready = 1'b0;
        wr_ptr      = '0;
        exp_wr      = 0;
        ev_model    = '0;
        to_model    = '0;
        bus.m_axis_tready = 1'b1;
        repeat (3) step();
        check("rst_tvalid", bus.m_axis_tvalid, 1'b0);
        check("rst_tdata", bus.m_axis_tdata, 32'h0);
        check("rst_rd_en", bus.fifo_rd_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_event_count", event_count, '0);
        check("rst_timeout_count", timeout_count, '0);
        rst = 1'b0;
        step();

        // Basic event with fixed words 1..4.
        enable = 1'b1;
        base   = pop_count;
        push_exp(32'hEB90_0000, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= NUM; i++) begin
            push_exp(32'(i), i == NUM, 1'b0, 1'b1);
            fifo_push(32'(i));
        end
        ev_model = ev_model + 1'b1;
        wait_idle();
        check("basic_event_count", event_count, 4'd1);
        check("basic_pops", pop_count - base, NUM);

        // Disabled with data waiting, then enable dropped mid-event.
        enable = 1'b0;
        run_event(NUM, 0);
        repeat (20) begin
            step();
            check("disabled_tvalid", bus.m_axis_tvalid, 1'b0);
            check("disabled_busy", busy, 1'b0);
        end
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (busy) break;
        end
        check("enable_starts", busy, 1'b1);
        step();
        step();
        enable = 1'b0;
        run_event(NUM, 0);
        for (int i = 0; i < 200; i++) begin
            step();
            if (!busy && (exp_wr - exp_rd == NUM + 1)) break;
        end
        repeat (10) step();
        check("drop_enable_idle", {busy, bus.m_axis_tvalid, bus.fifo_empty}, 3'b000);
        check("drop_enable_count", event_count, EVTW'(ev_model - 1'b1));
        enable = 1'b1;
        wait_idle();

        // Starvation: two words, then pads; a late word is kept for the next event.
        run_event(2, 0);
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.m_axis_tuser) break;
        end
        check("pad_seen", bus.m_axis_tuser, 1'b1);
        run_event(NUM, 0);
        wait_idle();
        check("timeout_count", timeout_count, to_model);
        check("event_count_after_pad", event_count, ev_model);

        // Random backpressure and dribbled FIFO fill.
        rand_tready = 1'b1;
        for (int e = 0; e < 20; e++)
            run_event(NUM, ($urandom_range(0, 1) == 1) ? 5 : 0);
        wait_idle();
        check("random_event_count", event_count, ev_model);
        check("random_timeout_count", timeout_count, to_model);
        rand_tready = 1'b0;

        // Reset in the middle of an event.
        base = pop_count;
        run_event(NUM, 0);
        for (int i = 0; i < 100; i++) begin
            step();
            if (pop_count - base >= 2) break;
        end
        check("two_words_popped", pop_count - base, 2);
        rst = 1'b1;
        #1;
        check("async_tvalid", bus.m_axis_tvalid, 1'b0);
        check("async_tdata", bus.m_axis_tdata, 32'h0);
        check("async_tlast", bus.m_axis_tlast, 1'b0);
        check("async_rd_en", bus.fifo_rd_en, 1'b0);
        check("async_busy", busy, 1'b0);
        check("async_counts", {event_count, timeout_count}, '0);
        step();
        step();
        rst      = 1'b0;
        ev_model = '0;
        to_model = '0;
        step();
        run_event(NUM, 0);
        wait_idle();
        check("post_rst_count", event_count, 4'd1);

        // Counter wrap: 16 completed events return the count to zero.
        for (int e = 0; e < 15; e++) run_event(NUM, 0);
        wait_idle();
        check("wrap_event_count", event_count, 4'd0);
        run_event(NUM, 0);
        wait_idle();
        check("after_wrap_count", event_count, 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
